// File: rtl/vga_mon_pkg.sv
// Shared FSM state type and 640x480@60 (25 MHz pixel clock) timing constants.
// Latency: n/a, declarations only.
// Backpressure: n/a.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        CHECK,
        LOCKED
    } mon_state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;
    localparam int VGA_LOCK_FRAMES     = 2;
    localparam int VGA_CNT_W           = 10;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises a raw sync pin, normalises polarity and flags start/end edges.
// Latency: pin change to edge pulse 2 clk, pulse is registered downstream on the 3rd.
// Backpressure: none, free-running sampler.
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic active,
    output logic start_edge,
    output logic end_edge
);

    logic [1:0] sync_q;
    logic       hist_q;
    logic       norm;

    assign norm = sync_q[1] ^ ACTIVE_LOW;

    // Reset to the inactive pin level so no phantom edge appears on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{ACTIVE_LOW}};
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sync_in};
            hist_q <= norm;
        end
    end

    assign active     = norm;
    assign start_edge = norm & ~hist_q;
    assign end_edge   = ~norm & hist_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures hsync/vsync timing and locks once it matches the expected format.
// Latency: pin edge to registered outputs 3 clk; locked falls 2^CNT_W clk after the last hsync start.
// Backpressure: none, passive observer of free-running sync inputs.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW,
    parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES,
    parameter int CNT_W           = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic             locked,
    output logic [CNT_W-1:0] h_total_o,
    output logic [CNT_W-1:0] v_total_o,
    output logic             h_err,
    output logic             v_err,
    output logic             frame_strobe
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_FRAMES);

    logic hs_act, hs_start, hs_end;
    logic vs_act, vs_start, vs_end;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (hsync_in),
        .active     (hs_act),
        .start_edge (hs_start),
        .end_edge   (hs_end)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (vsync_in),
        .active     (vs_act),
        .start_edge (vs_start),
        .end_edge   (vs_end)
    );

    logic [CNT_W-1:0] h_cnt, hw_cnt, line_cnt, vw_cnt;
    logic             h_seen, h_bad, v_bad;
    logic [CNT_W-1:0] h_meas, line_inc, v_meas;
    logic             h_sat, h_lost;
    logic             h_len_bad, h_wid_bad, v_len_bad, v_wid_bad;
    logic             frame_h_bad, frame_v_bad, frame_good;

    mon_state_t       state, state_next;
    logic [GW-1:0]    good_cnt, good_next, good_inc;
    logic             locked_d;

    // A start edge restarts the line, so a saturated count only means lost hsync
    // when no new start arrives in the same cycle.
    assign h_sat  = (h_cnt == CNT_MAX);
    assign h_lost = h_sat && !hs_start;
    assign h_meas = h_sat ? CNT_MAX : h_cnt + CNT_W'(1);

    assign line_inc = (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + CNT_W'(1);
    // A line starting together with vsync closes the ending frame.
    assign v_meas   = hs_start ? line_inc : line_cnt;

    assign h_len_bad = hs_start && h_seen && (h_meas != H_TOTAL_C);
    assign h_wid_bad = hs_end && h_seen && (hw_cnt != H_SYNC_C);
    assign v_len_bad = vs_start && (v_meas != V_TOTAL_C);
    assign v_wid_bad = vs_end && (vw_cnt != V_SYNC_C);

    assign frame_h_bad = h_bad | h_len_bad | h_wid_bad;
    assign frame_v_bad = v_bad | v_len_bad | v_wid_bad;
    assign frame_good  = !frame_h_bad && !frame_v_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt        <= '0;
            hw_cnt       <= '0;
            line_cnt     <= '0;
            vw_cnt       <= '0;
            h_seen       <= 1'b0;
            h_bad        <= 1'b0;
            v_bad        <= 1'b0;
            h_total_o    <= '0;
            v_total_o    <= '0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
            frame_strobe <= 1'b0;
            locked       <= 1'b0;
        end else begin
            if (hs_start) begin
                h_cnt <= '0;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end

            if (hs_start) begin
                hw_cnt <= CNT_W'(1);
            end else if (hs_act && hw_cnt != CNT_MAX) begin
                hw_cnt <= hw_cnt + CNT_W'(1);
            end

            if (h_lost) begin
                h_seen <= 1'b0;
            end else if (hs_start) begin
                h_seen <= 1'b1;
            end

            if (hs_start && h_seen) begin
                h_total_o <= h_meas;
            end

            if (vs_start) begin
                line_cnt <= '0;
            end else if (hs_start) begin
                line_cnt <= line_inc;
            end

            if (vs_start) begin
                vw_cnt <= hs_start ? CNT_W'(1) : '0;
            end else if (vs_act && hs_start && vw_cnt != CNT_MAX) begin
                vw_cnt <= vw_cnt + CNT_W'(1);
            end

            if (h_lost || vs_start) begin
                h_bad <= 1'b0;
                v_bad <= 1'b0;
            end else begin
                if (h_len_bad || h_wid_bad) h_bad <= 1'b1;
                if (v_wid_bad)              v_bad <= 1'b1;
            end

            if (vs_start) begin
                v_total_o <= v_meas;
                h_err     <= frame_h_bad;
                v_err     <= frame_v_bad;
            end

            frame_strobe <= vs_start;
            locked       <= locked_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    assign good_inc = good_cnt + GW'(1);

    // Frames are judged only at vsync start; losing hsync overrides everything.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        if (h_lost) begin
            state_next = SEARCH;
            good_next  = '0;
        end else if (vs_start) begin
            case (state)
                SEARCH: begin
                    state_next = MEASURE;
                    good_next  = '0;
                end
                MEASURE: begin
                    if (frame_good) begin
                        good_next  = GW'(1);
                        state_next = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
                    end else begin
                        good_next  = '0;
                    end
                end
                CHECK: begin
                    if (frame_good) begin
                        good_next = good_inc;
                        if (good_inc >= LOCK_C) state_next = LOCKED;
                    end else begin
                        good_next  = '0;
                        state_next = MEASURE;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        good_next  = '0;
                        state_next = MEASURE;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    good_next  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d = (state_next == LOCKED);
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench: scaled-down VGA timing (40x12 lines, 6-bit counters) on two monitors,
// one active-low with standard sync placement and one active-high with hsync/vsync aligned.
module tb_vga_sync_monitor;

    localparam int HT     = 40;
    localparam int HS     = 6;
    localparam int VT     = 12;
    localparam int VS     = 2;
    localparam int CW     = 6;
    localparam int HS_BEG = 30;
    localparam int VS_BEG = 9;
    localparam int BOUND  = 2 * HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b, hs_a, vs_a, hs_b, vs_b;
    logic          locked_a, h_err_a, v_err_a, fs_a;
    logic          locked_b, h_err_b, v_err_b, fs_b;
    logic [CW-1:0] ht_a, vt_a, ht_b, vt_b;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2), .CNT_W(CW)
    ) dut_a (
        .clk(clk), .rst(rst_a), .hsync_in(hs_a), .vsync_in(vs_a),
        .locked(locked_a), .h_total_o(ht_a), .v_total_o(vt_a),
        .h_err(h_err_a), .v_err(v_err_a), .frame_strobe(fs_a)
    );

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2), .CNT_W(CW)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hsync_in(hs_b), .vsync_in(vs_b),
        .locked(locked_b), .h_total_o(ht_b), .v_total_o(vt_b),
        .h_err(h_err_b), .v_err(v_err_b), .frame_strobe(fs_b)
    );

    int errors = 0;
    int checks = 0;
    int px = 0, ln = 0, line_len = HT, frame_lines = VT;
    bit hs_on = 1'b1;
    int tcnt = 0, t_hs = 0, str_a = 0, str_b = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: sample outputs at the falling edge, then drive the next pins.
    task automatic tick();
        @(negedge clk);
        tcnt++;
        if (fs_a) str_a++;
        if (fs_b) str_b++;
        hs_a = !(hs_on && px >= HS_BEG && px < HS_BEG + HS);
        vs_a = !(ln >= VS_BEG && ln < VS_BEG + VS);
        hs_b = hs_on && px < HS;
        vs_b = ln < VS;
        if (hs_on && px == HS_BEG) t_hs = tcnt;
        px++;
        if (px >= line_len) begin
            px       = 0;
            line_len = HT;
            ln++;
            if (ln >= frame_lines) ln = 0;
        end
    endtask

    task automatic wait_strobe(input int which, input string tag);
        int c0;
        int k;
        c0 = (which == 0) ? str_a : str_b;
        k  = 0;
        while (((which == 0) ? str_a : str_b) == c0 && k < BOUND) begin
            tick();
            k++;
        end
        check_val({tag, "_strobe"}, ((which == 0) ? str_a : str_b) - c0, 1);
    endtask

    task automatic tick_to(input int l, input int p);
        int k;
        k = 0;
        while (!(ln == l && px == p) && k < BOUND) begin
            tick();
            k++;
        end
    endtask

    task automatic check_a_zero(input string tag);
        check_val({tag, "_locked"}, int'(locked_a), 0);
        check_val({tag, "_htot"},   int'(ht_a), 0);
        check_val({tag, "_vtot"},   int'(vt_a), 0);
        check_val({tag, "_herr"},   int'(h_err_a), 0);
        check_val({tag, "_verr"},   int'(v_err_a), 0);
        check_val({tag, "_strb"},   int'(fs_a), 0);
    endtask

    task automatic relock_a(input string tag);
        wait_strobe(0, {tag, "1"});
        check_val({tag, "1_locked"}, int'(locked_a), 0);
        wait_strobe(0, {tag, "2"});
        check_val({tag, "2_locked"}, int'(locked_a), 0);
        wait_strobe(0, {tag, "3"});
        check_val({tag, "3_locked"}, int'(locked_a), 1);
        check_val({tag, "3_htot"},   int'(ht_a), HT);
        check_val({tag, "3_vtot"},   int'(vt_a), VT);
        check_val({tag, "3_herr"},   int'(h_err_a), 0);
        check_val({tag, "3_verr"},   int'(v_err_a), 0);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        hs_a  = 1'b1;
        vs_a  = 1'b1;
        hs_b  = 1'b0;
        vs_b  = 1'b0;
        repeat (3) tick();
        check_a_zero("reset");
        rst_a = 1'b0;

        // Lock from reset
        relock_a("lock");
        tick();
        check_val("strobe_pulse", int'(fs_a), 0);

        // One long line while locked
        line_len = HT + 1;
        tick_to(VS_BEG + 1, HS_BEG + 8);
        check_val("long_htot", int'(ht_a), HT + 1);
        wait_strobe(0, "long_end");
        check_val("long_herr",   int'(h_err_a), 1);
        check_val("long_verr",   int'(v_err_a), 0);
        check_val("long_locked", int'(locked_a), 0);
        check_val("long_htot2",  int'(ht_a), HT);
        wait_strobe(0, "long_g1");
        check_val("long_g1_locked", int'(locked_a), 0);
        check_val("long_g1_herr",   int'(h_err_a), 0);
        wait_strobe(0, "long_g2");
        check_val("long_relock", int'(locked_a), 1);

        // Short frames
        frame_lines = VT - 1;
        wait_strobe(0, "short1");
        check_val("short1_vtot",   int'(vt_a), VT - 1);
        check_val("short1_verr",   int'(v_err_a), 1);
        check_val("short1_herr",   int'(h_err_a), 0);
        check_val("short1_locked", int'(locked_a), 0);
        wait_strobe(0, "short2");
        check_val("short2_vtot",   int'(vt_a), VT - 1);
        check_val("short2_verr",   int'(v_err_a), 1);
        check_val("short2_locked", int'(locked_a), 0);
        frame_lines = VT;
        wait_strobe(0, "short_g1");
        check_val("short_g1_vtot",   int'(vt_a), VT);
        check_val("short_g1_verr",   int'(v_err_a), 0);
        check_val("short_g1_locked", int'(locked_a), 0);
        wait_strobe(0, "short_g2");
        check_val("short_relock", int'(locked_a), 1);

        // Hsync loss: locked drops 2^CW clocks after the last detected hsync start
        tick_to(VS_BEG, HS_BEG + HS + 1);
        hs_on = 1'b0;
        while (tcnt < t_hs + (1 << CW) + 2) tick();
        check_val("loss_hold", int'(locked_a), 1);
        tick();
        check_val("loss_drop", int'(locked_a), 0);
        tick_to(VS_BEG + 2, HS_BEG + HS + 1);
        hs_on = 1'b1;
        relock_a("loss");

        // One-cycle reset mid-frame while locked
        tick_to(3, 15);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check_a_zero("midrst");
        relock_a("midrst");

        // Active-high monitor with simultaneous hsync/vsync starts
        tick_to(5, 0);
        check_val("b_rst_locked", int'(locked_b), 0);
        check_val("b_rst_vtot",   int'(vt_b), 0);
        check_val("b_rst_strb",   int'(fs_b), 0);
        rst_b = 1'b0;
        wait_strobe(1, "b1");
        check_val("b1_locked", int'(locked_b), 0);
        wait_strobe(1, "b2");
        check_val("b2_locked", int'(locked_b), 0);
        wait_strobe(1, "b3");
        check_val("b3_locked", int'(locked_b), 1);
        check_val("b3_vtot",   int'(vt_b), VT);
        check_val("b3_htot",   int'(ht_b), HT);
        check_val("b3_herr",   int'(h_err_b), 0);
        check_val("b3_verr",   int'(v_err_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
